ram_dma: RTL and testbench
==========================

// Module: ram_dma
// PURPOSE
//   Memory-side initiator for the 32x8 data RAM: accepts FILL/COPY commands over a valid/ready
//   handshake and drives the RAM's addr/data_in/we port, sampling data_out for copies.
//   Sits between the control unit (or test host) and RAM; frees the CPU from byte-wise loops.
// PARAMETERS
//   ADDR_W  5  RAM address width (depth = 2**ADDR_W = 32)
//   DATA_W  8  RAM data width
// PORTS
//   clk           in   1         system clock, all logic on posedge
//   rst           in   1         synchronous, active-high reset
//   cmd_valid     in   1         command present
//   cmd_ready     out  1         high only in IDLE; command accepted when valid&&ready at posedge
//   cmd_op        in   1         0=FILL, 1=COPY
//   cmd_src       in   ADDR_W    COPY source start address (ignored for FILL)
//   cmd_dst       in   ADDR_W    destination start address
//   cmd_len       in   ADDR_W+1  byte count 0..32; values >32 clamp to 32
//   cmd_fill      in   DATA_W    FILL byte value
//   busy          out  1         high from cycle after accept through DONE cycle
//   done          out  1         one-cycle pulse when command completes
//   ram_addr      out  ADDR_W    to RAM addr
//   ram_data_in   out  DATA_W    to RAM data_in
//   ram_we        out  1         to RAM we (write on posedge while high)
//   ram_data_out  in   DATA_W    from RAM data_out
//   checksum      out  DATA_W    only with RAM_DMA_CHECKSUM_EN
// BEHAVIOUR
//   Reset: state=IDLE, cmd_ready=1, busy=0, done=0, ram_we=0, ram_addr=0, ram_data_in=0.
//   All command fields latched at accept; inputs ignored while busy.
//   FSM: IDLE -> FILL_WR | CP_RD (len>0) | DONE (len==0).
//     FILL_WR: addr=dst+i, data=fill, we=1, one byte per cycle; after last byte -> DONE.
//     CP_RD: addr=src+i, we=0.  CP_CAP: addr held at src+i, hold_reg<=ram_data_out.
//     CP_WR: addr=dst+i, data=hold_reg, we=1; -> CP_RD, or DONE after last byte.
//     DONE: done=1, busy=1, we=0 for exactly one cycle -> IDLE.
//   Latency from accept edge: FILL = len write cycles + 1; COPY = 3*len + 1; len=0 -> done next cycle.
//   Two-cycle read (RD+CAP) is valid for both asynchronous and 1-cycle synchronous RAM reads.
//   Addresses wrap modulo 2**ADDR_W (31 -> 0) independently for src and dst.
//   Overlapping COPY is strictly sequential byte-by-byte ascending; results follow that order.
//   ram_we is never high outside FILL_WR/CP_WR; ram_data_in is don't-care when we=0.
//   rst mid-command: next cycle IDLE with ram_we=0, no done pulse; partial writes remain.
//   New command may be accepted the cycle after DONE (back-to-back gap = 1 cycle in IDLE).
// CONFIGURATION
//   RAM_DMA_CHECKSUM_EN defined: checksum port present; cleared to 0 at accept, adds every
//     written byte mod 2**DATA_W; stable and valid from done pulse until next accept; reset=0.
//   Not defined: checksum port and accumulator absent; all other behaviour identical.
// STRUCTURE
//   ram_dma_pkg: ADDR_W/DATA_W defaults, LEN_W=ADDR_W+1, typedef enum dma_op_e {OP_FILL,OP_COPY},
//     typedef enum dma_state_e {IDLE,FILL_WR,CP_RD,CP_CAP,CP_WR,DONE}.
//   Single module; no sub-module (address counters and FSM are small). Bench reuses existing RAM.
// TESTING
//   Reset: assert rst 2 cycles -> cmd_ready=1, busy=0, done=0, ram_we=0.
//   FILL dst=3 len=4 fill=8'h5A -> we high 4 consecutive cycles at addr 3,4,5,6; done in cycle 5; RAM[3..6]=5A, RAM[7] unchanged.
//   COPY src=1 dst=10 len=2 with RAM[1]=AA, RAM[2]=55 -> RAM[10]=AA, RAM[11]=55; done 7 cycles after accept.
//   Wrap: FILL dst=30 len=4 fill=8'h11 -> writes addr 30,31,0,1; COPY src=31 dst=5 len=2 reads 31,0.
//   Edge lengths: len=0 -> no we, done 1 cycle after accept; len=40 -> exactly 32 writes; cmd_valid while busy ignored.
//   rst during CP_WR of 3-byte COPY -> ram_we=0 next cycle, no done; following FILL runs correctly;
//     with RAM_DMA_CHECKSUM_EN, FILL len=3 fill=8'h90 -> checksum=8'hB0 at done.

Source files
------------

// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: shared types and default sizes for the 32x8 RAM DMA engine.
//   DEF_ADDR_W / DEF_DATA_W : default RAM address / data widths
//   DEF_LEN_W               : byte-count width (one more bit than the address so 32 fits)
//   dma_op_e                : command opcode (FILL / COPY)
//   dma_state_e             : engine FSM states
package ram_dma_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_LEN_W  = DEF_ADDR_W + 1;

   typedef enum logic {
      OP_FILL = 1'b0,
      OP_COPY = 1'b1
   } dma_op_e;

   typedef enum logic [2:0] {
      IDLE,
      FILL_WR,
      CP_RD,
      CP_CAP,
      CP_WR,
      DONE
   } dma_state_e;

endpackage

// File: rtl/ram_dma.sv
// ram_dma: memory-side initiator for the 32x8 data RAM.
//   Accepts FILL / COPY commands over a valid/ready handshake and drives the
//   RAM addr/data_in/we port, sampling data_out during copies.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_op                   0 = FILL, 1 = COPY
//   cmd_src, cmd_dst         start addresses (src used by COPY only)
//   cmd_len                  byte count, values above 2**ADDR_W clamp to 2**ADDR_W
//   cmd_fill                 FILL byte
//   busy, done               busy from cycle after accept through done; done is a 1-cycle pulse
//   ram_addr, ram_data_in, ram_we, ram_data_out   RAM port
//   checksum                 present only when RAM_DMA_CHECKSUM_EN is defined: sum of
//                            all bytes written by the last command, modulo 2**DATA_W
// Optional feature macro: RAM_DMA_CHECKSUM_EN
module ram_dma
   import ram_dma_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic [DATA_W-1:0] cmd_fill,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_DMA_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(2 ** ADDR_W);
   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   dma_state_e        state_reg;
   logic [ADDR_W-1:0] src_reg;      // current read address (COPY)
   logic [ADDR_W-1:0] dst_reg;      // current write address
   logic [LEN_W-1:0]  rem_reg;      // bytes still to write, including the current one
   logic [DATA_W-1:0] hold_reg;     // write data: fill byte, or byte captured from RAM
   logic [ADDR_W-1:0] ram_addr_reg;
   logic              ram_we_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              ready_reg;
   logic [LEN_W-1:0]  len_clamped;

   always_comb begin
      len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
   end

   // All outputs are registered: each transition loads the values the
   // destination state presents during its cycle.  Address registers are
   // ADDR_W wide, so src/dst wrap modulo 2**ADDR_W on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         src_reg      <= '0;
         dst_reg      <= '0;
         rem_reg      <= '0;
         hold_reg     <= '0;
         ram_addr_reg <= '0;
         ram_we_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         ready_reg    <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  src_reg   <= cmd_src;
                  dst_reg   <= cmd_dst;
                  rem_reg   <= len_clamped;
                  busy_reg  <= 1'b1;
                  ready_reg <= 1'b0;
                  if (len_clamped == '0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else if (dma_op_e'(cmd_op) == OP_FILL) begin
                     state_reg    <= FILL_WR;
                     ram_addr_reg <= cmd_dst;
                     hold_reg     <= cmd_fill;
                     ram_we_reg   <= 1'b1;
                  end else begin
                     state_reg    <= CP_RD;
                     ram_addr_reg <= cmd_src;
                  end
               end
            end
            FILL_WR: begin
               if (rem_reg == LEN_ONE) begin
                  state_reg  <= DONE;
                  ram_we_reg <= 1'b0;
                  done_reg   <= 1'b1;
               end else begin
                  dst_reg      <= dst_reg + ADDR_ONE;
                  ram_addr_reg <= dst_reg + ADDR_ONE;
                  rem_reg      <= rem_reg - LEN_ONE;
               end
            end
            CP_RD: begin
               // Address held one more cycle so a synchronous-read RAM has
               // its data on data_out by the end of CP_CAP.
               state_reg <= CP_CAP;
            end
            CP_CAP: begin
               state_reg    <= CP_WR;
               hold_reg     <= ram_data_out;
               ram_addr_reg <= dst_reg;
               ram_we_reg   <= 1'b1;
            end
            CP_WR: begin
               ram_we_reg <= 1'b0;
               if (rem_reg == LEN_ONE) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg    <= CP_RD;
                  src_reg      <= src_reg + ADDR_ONE;
                  dst_reg      <= dst_reg + ADDR_ONE;
                  ram_addr_reg <= src_reg + ADDR_ONE;
                  rem_reg      <= rem_reg - LEN_ONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               ready_reg <= 1'b1;
            end
            default: begin
               state_reg  <= IDLE;
               ram_we_reg <= 1'b0;
               done_reg   <= 1'b0;
               busy_reg   <= 1'b0;
               ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready   = ready_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign ram_addr    = ram_addr_reg;
   assign ram_data_in = hold_reg;
   assign ram_we      = ram_we_reg;

`ifdef RAM_DMA_CHECKSUM_EN
   logic [DATA_W-1:0] sum_reg;

   // A byte counts when the RAM actually takes it (we high at the edge),
   // so the final byte is included by the time done is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_reg <= '0;
      end else if (state_reg == IDLE && cmd_valid) begin
         sum_reg <= '0;
      end else if (ram_we_reg) begin
         sum_reg <= sum_reg + hold_reg;
      end
   end

   assign checksum = sum_reg;
`endif

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: self-checking bench for ram_dma with a 32x8 synchronous-read RAM.
// A behavioural model builds, per command, the expected cycle-by-cycle RAM
// port activity and the final memory image; one negedge process compares.
module tb_ram_dma;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_op = 1'b0;
   logic [4:0] cmd_src = '0;
   logic [4:0] cmd_dst = '0;
   logic [5:0] cmd_len = '0;
   logic [7:0] cmd_fill = '0;
   logic       busy;
   logic       done;
   logic [4:0] ram_addr;
   logic [7:0] ram_data_in;
   logic       ram_we;
   logic [7:0] ram_data_out;
`ifdef RAM_DMA_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   always #5 clk = ~clk;

   ram_dma dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
      .busy(busy), .done(done),
      .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
      .ram_data_out(ram_data_out)
`ifdef RAM_DMA_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   // RAM with a host port for preloading while the DMA is idle
   logic [7:0] mem [32];
   logic       host_we = 1'b0;
   logic [4:0] host_addr = '0;
   logic [7:0] host_data = '0;
   logic [7:0] ram_q;

   always @(posedge clk) begin
      if (host_we) mem[host_addr] <= host_data;
      else if (ram_we) mem[ram_addr] <= ram_data_in;
      ram_q <= mem[ram_addr];
   end
   assign ram_data_out = ram_q;

   // model state
   typedef struct {
      bit         we, dn, bz, rdy, ca, cd;
      logic [4:0] addr;
      logic [7:0] data;
      logic [7:0] cks;
   } exp_t;

   exp_t       exp_q [$];
   logic [7:0] m [32];
   int         n_checks = 0;
   int         n_fail = 0;
   bit         checking_on = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push(bit we, bit dn, bit bz, bit rdy, bit ca, bit cd,
                                logic [4:0] a, logic [7:0] d, logic [7:0] c);
      exp_t e;
      e.we = we; e.dn = dn; e.bz = bz; e.rdy = rdy; e.ca = ca; e.cd = cd;
      e.addr = a; e.data = d; e.cks = c;
      exp_q.push_back(e);
   endfunction

   // Expected behaviour for one command; only the first nbytes bytes are
   // modelled (used when the command is cut short by reset). Returns latency.
   function automatic int build(bit op, logic [4:0] src, logic [4:0] dst,
                                logic [5:0] len, logic [7:0] fill, int nbytes);
      int         eff;
      logic [7:0] cks;
      logic [7:0] d;
      logic [4:0] sa, da;
      eff = (len > 6'd32) ? 32 : int'(len);
      cks = 8'h00;
      for (int i = 0; i < eff && i < nbytes; i++) begin
         sa = src + 5'(i);
         da = dst + 5'(i);
         if (!op) begin
            push(1, 0, 1, 0, 1, 1, da, fill, 8'h00);
            m[da] = fill;
            cks += fill;
         end else begin
            d = m[sa];
            push(0, 0, 1, 0, 1, 0, sa, 8'h00, 8'h00);
            push(0, 0, 1, 0, 1, 0, sa, 8'h00, 8'h00);
            push(1, 0, 1, 0, 1, 1, da, d, 8'h00);
            m[da] = d;
            cks += d;
         end
      end
      if (nbytes >= eff) begin
         push(0, 1, 1, 0, 0, 0, 5'd0, 8'h00, cks);
         push(0, 0, 0, 1, 0, 0, 5'd0, 8'h00, 8'h00);
      end
      return (op ? 3 * eff : eff) + 1;
   endfunction

   // single compare process
   always @(negedge clk) begin
      exp_t e;
      if (checking_on) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ram_we", ram_we, e.we);
            chk("done", done, e.dn);
            chk("busy", busy, e.bz);
            chk("cmd_ready", cmd_ready, e.rdy);
            if (e.ca) chk("ram_addr", ram_addr, e.addr);
            if (e.cd) chk("ram_data_in", ram_data_in, e.data);
`ifdef RAM_DMA_CHECKSUM_EN
            if (e.dn) chk("checksum", checksum, e.cks);
`endif
         end else begin
            chk("idle_we", ram_we, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_ready", cmd_ready, 1'b1);
         end
      end
   end

   task automatic host_write(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      host_we = 1'b1; host_addr = a; host_data = d;
      @(posedge clk); #1;
      host_we = 1'b0;
      m[a] = d;
   endtask

   task automatic check_mem();
      for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), mem[i], m[i]);
   endtask

   task automatic run_cmd(input bit op, input logic [4:0] src, input logic [4:0] dst,
                          input logic [5:0] len, input logic [7:0] fill, input bit noise,
                          output int done_c, output int we_cnt);
      int lat;
      int c;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst;
      cmd_len = len; cmd_fill = fill;
      @(posedge clk); #1;
      lat = build(op, src, dst, len, fill, 64);
      if (noise && lat > 1) begin
         cmd_op = 1'($urandom_range(0, 1)); cmd_src = 5'($urandom);
         cmd_dst = 5'($urandom); cmd_len = 6'($urandom_range(0, 40));
         cmd_fill = 8'($urandom);
      end else begin
         cmd_valid = 1'b0;
      end
      done_c = 0; we_cnt = 0; c = 1;
      while (c <= lat + 50) begin
         if (ram_we) we_cnt++;
         if (done && done_c == 0) done_c = c;
         if (c >= lat - 1) cmd_valid = 1'b0;
         if (done_c != 0) break;
         @(posedge clk); #1;
         c++;
      end
      cmd_valid = 1'b0;
      if (done_c == 0) begin
         chk("done_timeout", 32'd0, 32'd1);
         exp_q.delete();
      end
      @(posedge clk); #1;
      $display("cmd op=%0d src=%0d dst=%0d len=%0d fill=%02h noise=%0d done_cycle=%0d writes=%0d",
               op, src, dst, len, fill, noise, done_c, we_cnt);
      check_mem();
   endtask

   initial begin
      int dc, wc;
      bit op;
      // reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_we", ram_we, 1'b0);
      chk("rst_addr", ram_addr, 5'd0);
      chk("rst_data", ram_data_in, 8'h00);
`ifdef RAM_DMA_CHECKSUM_EN
      chk("rst_checksum", checksum, 8'h00);
`endif
      rst = 1'b0;
      checking_on = 1'b1;

      for (int i = 0; i < 32; i++) host_write(5'(i), 8'($urandom));
      host_write(5'd7, 8'h77);
      host_write(5'd1, 8'hAA);
      host_write(5'd2, 8'h55);

      // FILL dst=3 len=4
      run_cmd(1'b0, 5'd0, 5'd3, 6'd4, 8'h5A, 1'b0, dc, wc);
      chk("fill4_done_cycle", dc, 5);
      chk("fill4_writes", wc, 4);
      chk("fill4_mem3", mem[3], 8'h5A);
      chk("fill4_mem6", mem[6], 8'h5A);
      chk("fill4_mem7", mem[7], 8'h77);

      // COPY 1 -> 10 len=2
      run_cmd(1'b1, 5'd1, 5'd10, 6'd2, 8'h00, 1'b0, dc, wc);
      chk("copy2_done_cycle", dc, 7);
      chk("copy2_mem10", mem[10], 8'hAA);
      chk("copy2_mem11", mem[11], 8'h55);

      // wrap
      run_cmd(1'b0, 5'd0, 5'd30, 6'd4, 8'h11, 1'b0, dc, wc);
      chk("wrapfill_mem31", mem[31], 8'h11);
      chk("wrapfill_mem0", mem[0], 8'h11);
      chk("wrapfill_mem1", mem[1], 8'h11);
      run_cmd(1'b1, 5'd31, 5'd5, 6'd2, 8'h00, 1'b0, dc, wc);
      chk("wrapcopy_mem5", mem[5], 8'h11);
      chk("wrapcopy_mem6", mem[6], 8'h11);

      // edge lengths, with busy-time noise on the command inputs
      run_cmd(1'b0, 5'd0, 5'd9, 6'd0, 8'hEE, 1'b0, dc, wc);
      chk("len0_done_cycle", dc, 1);
      chk("len0_writes", wc, 0);
      run_cmd(1'b0, 5'd0, 5'd17, 6'd40, 8'h3C, 1'b1, dc, wc);
      chk("len40_writes", wc, 32);
      chk("len40_done_cycle", dc, 33);
      run_cmd(1'b1, 5'd8, 5'd9, 6'd3, 8'h00, 1'b1, dc, wc);
      chk("overlap_done_cycle", dc, 10);
      chk("overlap_mem11", mem[11], 8'h3C);

      // reset during CP_WR of the second byte of a 3-byte COPY
      for (int i = 0; i < 4; i++) host_write(5'(12 + i), 8'(8'hC0 + i));
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_src = 5'd12; cmd_dst = 5'd24; cmd_len = 6'd3;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      void'(build(1'b1, 5'd12, 5'd24, 6'd3, 8'h00, 2));
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_we", ram_we, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_addr", ram_addr, 5'd0);
`ifdef RAM_DMA_CHECKSUM_EN
      chk("midrst_checksum", checksum, 8'h00);
`endif
      repeat (4) begin
         @(posedge clk); #1;
         chk("midrst_no_done", done, 1'b0);
      end
      $display("cmd op=1 src=12 dst=24 len=3 cut by reset in CP_WR");
      check_mem();
      chk("midrst_mem25", mem[25], 8'hC1);

      run_cmd(1'b0, 5'd0, 5'd20, 6'd3, 8'h90, 1'b0, dc, wc);
      chk("postrst_done_cycle", dc, 4);
      chk("postrst_mem22", mem[22], 8'h90);
`ifdef RAM_DMA_CHECKSUM_EN
      chk("postrst_checksum_hold", checksum, 8'hB0);
`endif

      // randomized commands
      for (int k = 0; k < 40; k++) begin
         op = 1'($urandom_range(0, 1));
         run_cmd(op, 5'($urandom), 5'($urandom),
                 6'(($urandom_range(0, 7) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 12)),
                 8'($urandom), 1'($urandom_range(0, 1)), dc, wc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
